// File: rtl/sound_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sound_arbiter_pkg
// Purpose  : Shared types and constants for the buzzer arbiter: state
//            encoding, active-source encoding and counter widths.
// Revision : 1.0 - initial release
// ============================================================================
package sound_arbiter_pkg;

    // Counter widths: tone half-period counter and millisecond counter
    localparam int c_TONE_W = 16;
    localparam int c_MS_W   = 10;

    // Arbiter state encoding
    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE  = 3'd0;
    localparam state_t c_ST_WARN  = 3'd1;
    localparam state_t c_ST_HIT   = 3'd2;
    localparam state_t c_ST_OVER1 = 3'd3;
    localparam state_t c_ST_OVER2 = 3'd4;
    localparam state_t c_ST_OVER3 = 3'd5;

    // Source-now-playing encoding; numeric order matches priority
    localparam logic [1:0] c_SRC_NONE = 2'd0;
    localparam logic [1:0] c_SRC_WARN = 2'd1;
    localparam logic [1:0] c_SRC_HIT  = 2'd2;
    localparam logic [1:0] c_SRC_OVER = 2'd3;

    // Map an arbiter state onto the source it represents
    function automatic logic [1:0] state_to_src(input state_t s);
        logic [1:0] v;
        v = c_SRC_NONE;
        case (s)
            c_ST_WARN:                        v = c_SRC_WARN;
            c_ST_HIT:                         v = c_SRC_HIT;
            c_ST_OVER1, c_ST_OVER2, c_ST_OVER3: v = c_SRC_OVER;
            default:                          v = c_SRC_NONE;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sound_arbiter_tone_gen.sv
`default_nettype none
// ============================================================================
// Module   : sound_arbiter_tone_gen
// Purpose  : Square-wave generator. The output toggles every 'half' enabled
//            clocks; 'clear' restarts the phase with the output low.
// Revision : 1.0 - initial release
// ============================================================================
module sound_arbiter_tone_gen
    import sound_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,     // asynchronous, active low
    input  logic                clear,
    input  logic [c_TONE_W-1:0] half,    // must be >= 2
    input  logic                en,
    output logic                wave
);

    localparam logic [c_TONE_W-1:0] c_ONE = c_TONE_W'(1);

    logic [c_TONE_W-1:0] r_cnt;
    logic                r_wave;
    logic                w_last;

    // Last count of the current half period
    assign w_last = (r_cnt == (half - c_ONE));

    // Half-period counter and output toggle; clear has priority over counting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_wave <= 1'b0;
        end else if (clear) begin
            r_cnt  <= '0;
            r_wave <= 1'b0;
        end else if (en) begin
            if (w_last) begin
                r_cnt  <= '0;
                r_wave <= ~r_wave;
            end else begin
                r_cnt  <= r_cnt + c_ONE;
            end
        end
    end

    assign wave = r_wave;

endmodule
`default_nettype wire

// File: rtl/sound_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sound_arbiter
// Purpose  : Shares the buzzer between hit chirp, countdown warning tick and
//            the three-note game-over jingle. Fixed priority OVER > HIT >
//            WARN with preemption; one tone generator is fed the half period
//            of whichever sound is playing.
// Options  : SOUND_MUTE_EN - adds a 'mute' input that forces beep low while
//            the arbiter, counters and status outputs keep running.
// Revision : 1.0 - initial release
// ============================================================================
module sound_arbiter
    import sound_arbiter_pkg::*;
#(
    // Every *_HALF value must lie in [2, 65535]
    parameter int HIT_HALF     = 28409,
    parameter int WARN_HALF    = 56818,
    parameter int OVER_HALF0   = 28409,
    parameter int OVER_HALF1   = 37936,
    parameter int OVER_HALF2   = 56818,
    parameter int HIT_MS       = 100,
    parameter int WARN_MS      = 50,
    parameter int OVER_NOTE_MS = 300
) (
    input  logic       clk,
    input  logic       rst,          // asynchronous, active low
    input  logic       tick_ms,
    input  logic       req_hit,
    input  logic       req_warn,
    input  logic       req_over,
`ifdef SOUND_MUTE_EN
    input  logic       mute,
`endif
    output logic       beep,
    output logic       busy,
    output logic [1:0] active_src
);

    localparam logic [c_TONE_W-1:0] c_HIT_HALF   = c_TONE_W'(HIT_HALF);
    localparam logic [c_TONE_W-1:0] c_WARN_HALF  = c_TONE_W'(WARN_HALF);
    localparam logic [c_TONE_W-1:0] c_OVER_HALF0 = c_TONE_W'(OVER_HALF0);
    localparam logic [c_TONE_W-1:0] c_OVER_HALF1 = c_TONE_W'(OVER_HALF1);
    localparam logic [c_TONE_W-1:0] c_OVER_HALF2 = c_TONE_W'(OVER_HALF2);

    // Last ms count of each note; the note ends on the tick seen at this count
    localparam logic [c_MS_W-1:0] c_HIT_END  = c_MS_W'(HIT_MS - 1);
    localparam logic [c_MS_W-1:0] c_WARN_END = c_MS_W'(WARN_MS - 1);
    localparam logic [c_MS_W-1:0] c_OVER_END = c_MS_W'(OVER_NOTE_MS - 1);
    localparam logic [c_MS_W-1:0] c_MS_ONE   = c_MS_W'(1);

    state_t              r_state;
    state_t              w_next;
    logic                w_enter;     // (re)entering a sounding state
    logic                w_clear;     // restart tone and ms counters
    logic                w_note_end;
    logic [c_MS_W-1:0]   r_ms_cnt;
    logic [c_MS_W-1:0]   w_dur_end;
    logic [c_TONE_W-1:0] w_half;
    logic                w_wave;

    // Tone half period and note length of the sound now playing
    always_comb begin
        w_half    = c_HIT_HALF;
        w_dur_end = c_HIT_END;
        case (r_state)
            c_ST_WARN: begin
                w_half    = c_WARN_HALF;
                w_dur_end = c_WARN_END;
            end
            c_ST_HIT: begin
                w_half    = c_HIT_HALF;
                w_dur_end = c_HIT_END;
            end
            c_ST_OVER1: begin
                w_half    = c_OVER_HALF0;
                w_dur_end = c_OVER_END;
            end
            c_ST_OVER2: begin
                w_half    = c_OVER_HALF1;
                w_dur_end = c_OVER_END;
            end
            c_ST_OVER3: begin
                w_half    = c_OVER_HALF2;
                w_dur_end = c_OVER_END;
            end
            default: begin
                w_half    = c_HIT_HALF;
                w_dur_end = c_HIT_END;
            end
        endcase
    end

    assign w_note_end = (r_state != c_ST_IDLE) && tick_ms && (r_ms_cnt == w_dur_end);

    // Next state: granted requests are judged against the current state and
    // take precedence over the note-end transition of the same cycle
    always_comb begin
        w_next  = r_state;
        w_enter = 1'b0;
        if (req_over && (r_state != c_ST_OVER1) && (r_state != c_ST_OVER2) &&
            (r_state != c_ST_OVER3)) begin
            w_next  = c_ST_OVER1;
            w_enter = 1'b1;
        end else if (req_hit && ((r_state == c_ST_IDLE) || (r_state == c_ST_WARN) ||
                                 (r_state == c_ST_HIT))) begin
            w_next  = c_ST_HIT;
            w_enter = 1'b1;
        end else if (req_warn && (r_state == c_ST_IDLE)) begin
            w_next  = c_ST_WARN;
            w_enter = 1'b1;
        end else if (w_note_end) begin
            case (r_state)
                c_ST_OVER1: begin
                    w_next  = c_ST_OVER2;
                    w_enter = 1'b1;
                end
                c_ST_OVER2: begin
                    w_next  = c_ST_OVER3;
                    w_enter = 1'b1;
                end
                default: begin
                    w_next  = c_ST_IDLE;
                    w_enter = 1'b0;
                end
            endcase
        end
    end

    // Counters restart on every entry and are held at zero while idle
    assign w_clear = w_enter || (w_next == c_ST_IDLE);

    // Arbiter state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Millisecond duration counter of the current note
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ms_cnt <= '0;
        end else if (w_clear) begin
            r_ms_cnt <= '0;
        end else if (tick_ms) begin
            r_ms_cnt <= r_ms_cnt + c_MS_ONE;
        end
    end

    sound_arbiter_tone_gen u_tone (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .half  (w_half),
        .en    (r_state != c_ST_IDLE),
        .wave  (w_wave)
    );

    assign busy       = (r_state != c_ST_IDLE);
    assign active_src = state_to_src(r_state);

`ifdef SOUND_MUTE_EN
    // Muting only gates the pin so the waveform phase is kept
    assign beep = w_wave & ~mute;
`else
    assign beep = w_wave;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sound_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sound_arbiter
// Purpose  : Scoreboard bench for sound_arbiter. Each scenario queues the
//            hand-derived sequence of output changes ({active_src, busy,
//            beep} plus clocks since the previous change); a monitor compares
//            every observed change against the queue.
// Options  : SOUND_MUTE_EN - also exercises the mute input.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sound_arbiter;

    localparam int TICK = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_ms;
    logic       req_hit;
    logic       req_warn;
    logic       req_over;
    logic       beep;
    logic       busy;
    logic [1:0] active_src;
`ifdef SOUND_MUTE_EN
    logic       mute;
`endif

    sound_arbiter #(
        .HIT_HALF     (4),
        .WARN_HALF    (6),
        .OVER_HALF0   (3),
        .OVER_HALF1   (5),
        .OVER_HALF2   (7),
        .HIT_MS       (3),
        .WARN_MS      (2),
        .OVER_NOTE_MS (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_ms    (tick_ms),
        .req_hit    (req_hit),
        .req_warn   (req_warn),
        .req_over   (req_over),
`ifdef SOUND_MUTE_EN
        .mute       (mute),
`endif
        .beep       (beep),
        .busy       (busy),
        .active_src (active_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tid;
        int         idx;
        logic [1:0] src;
        logic       busy;
        logic       beep;
        int         gap;   // clocks since previous change, -1 = don't care
    } ev_t;

    ev_t exp_q[$];
    int  checks  = 0;
    int  errors  = 0;
    int  tphase  = 0;
    int  cur_tid = 0;
    int  cur_idx = 0;
    bit  done    = 1'b0;

    task automatic push_ev(input logic [1:0] s, input logic b, input int g);
        ev_t e;
        e.tid  = cur_tid;
        e.idx  = cur_idx;
        e.src  = s;
        e.busy = (s != 2'd0);
        e.beep = b;
        e.gap  = g;
        cur_idx = cur_idx + 1;
        exp_q.push_back(e);
    endtask

    // n beep toggles, starting with a rising edge
    task automatic push_tone(input logic [1:0] s, input int n, input int g0, input int g);
        for (int i = 0; i < n; i++) begin
            push_ev(s, ((i % 2) == 0), (i == 0) ? g0 : g);
        end
    endtask

    task automatic start_test(input int id);
        cur_tid = id;
        cur_idx = 0;
        tphase  = 0;
    endtask

    // Drive inputs for the next edge, then wait for it
    task automatic step(input logic h, input logic w, input logic o);
        req_hit  = h;
        req_warn = w;
        req_over = o;
        tick_ms  = (tphase == TICK - 1);
        tphase   = (tphase == TICK - 1) ? 0 : tphase + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every change of the observable outputs pops one expectation
    initial begin : monitor
        logic [3:0] prev;
        logic [3:0] cur;
        bit         first;
        int         since;
        ev_t        e;
        first = 1'b1;
        since = 0;
        prev  = '0;
        while (!done) begin
            @(negedge clk);
            since = since + 1;
            cur   = {active_src, busy, beep};
            if (first || (cur !== prev)) begin
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected change at %0t: got src=%0d busy=%0d beep=%0d gap=%0d, want no change",
                             $time, active_src, busy, beep, since);
                end else begin
                    e = exp_q.pop_front();
                    if ((active_src !== e.src) || (busy !== e.busy) || (beep !== e.beep) ||
                        ((e.gap >= 0) && (since != e.gap))) begin
                        errors = errors + 1;
                        $display("FAIL ev t%0d#%0d at %0t: got src=%0d busy=%0d beep=%0d gap=%0d, want src=%0d busy=%0d beep=%0d gap=%0d",
                                 e.tid, e.idx, $time, active_src, busy, beep, since,
                                 e.src, e.busy, e.beep, e.gap);
                    end
                end
                prev  = cur;
                since = 0;
                first = 1'b0;
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL missing ev t%0d#%0d: got nothing, want src=%0d busy=%0d beep=%0d gap=%0d",
                     e.tid, e.idx, e.src, e.busy, e.beep, e.gap);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Stimulus
    initial begin : stim
        rst      = 1'b0;
        tick_ms  = 1'b0;
        req_hit  = 1'b0;
        req_warn = 1'b0;
        req_over = 1'b0;
`ifdef SOUND_MUTE_EN
        mute     = 1'b0;
`endif
        // Reset state
        start_test(0);
        push_ev(2'd0, 1'b0, -1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(5);

        // 1: hit from idle, ends on third tick (edge 59)
        start_test(1);
        push_ev(2'd2, 1'b0, -1);
        push_tone(2'd2, 14, 4, 4);
        push_ev(2'd0, 1'b0, 3);
        step(1'b1, 1'b0, 1'b0);
        idle(75);

        // 2: warn and hit together, hit wins and warn is dropped
        start_test(2);
        push_ev(2'd2, 1'b0, -1);
        push_tone(2'd2, 14, 4, 4);
        push_ev(2'd0, 1'b0, 3);
        step(1'b1, 1'b1, 1'b0);
        idle(75);

        // 3: warn preempted by over at edge 10, then the three-note jingle
        start_test(3);
        push_ev(2'd1, 1'b0, -1);
        push_ev(2'd1, 1'b1, 6);
        push_ev(2'd3, 1'b0, 4);
        push_tone(2'd3, 9, 3, 3);
        push_ev(2'd3, 1'b0, 2);
        push_tone(2'd3, 7, 5, 5);
        push_ev(2'd3, 1'b0, 5);
        push_tone(2'd3, 5, 7, 7);
        push_ev(2'd0, 1'b0, 5);
        step(1'b0, 1'b1, 1'b0);
        idle(9);
        step(1'b0, 1'b0, 1'b1);
        idle(130);

        // 4: hit during the second jingle note is ignored
        start_test(4);
        push_ev(2'd3, 1'b0, -1);
        push_tone(2'd3, 12, 3, 3);
        push_tone(2'd3, 7, 8, 5);
        push_ev(2'd3, 1'b0, 5);
        push_tone(2'd3, 5, 7, 7);
        push_ev(2'd0, 1'b0, 5);
        step(1'b0, 1'b0, 1'b1);
        idle(49);
        step(1'b1, 1'b0, 1'b0);
        idle(90);

        // 5: second hit at edge 22 restarts tone and duration (ends at 79, not 59)
        start_test(5);
        push_ev(2'd2, 1'b0, -1);
        push_tone(2'd2, 5, 4, 4);
        push_ev(2'd2, 1'b0, 2);
        push_tone(2'd2, 14, 4, 4);
        push_ev(2'd0, 1'b0, 1);
        step(1'b1, 1'b0, 1'b0);
        idle(21);
        step(1'b1, 1'b0, 1'b0);
        idle(80);

        // 6: asynchronous reset mid-hit, silent afterwards
        start_test(6);
        push_ev(2'd2, 1'b0, -1);
        push_tone(2'd2, 3, 4, 4);
        push_ev(2'd0, 1'b0, 1);
        step(1'b1, 1'b0, 1'b0);
        idle(13);
        rst = 1'b0;
        idle(3);
        rst = 1'b1;
        idle(80);

`ifdef SOUND_MUTE_EN
        // 7: muted hit keeps status and duration, beep stays low
        start_test(7);
        mute = 1'b1;
        push_ev(2'd2, 1'b0, -1);
        push_ev(2'd0, 1'b0, 59);
        step(1'b1, 1'b0, 1'b0);
        idle(75);
        mute = 1'b0;
`endif

        done = 1'b1;
    end

endmodule
`default_nettype wire
